// File: rtl/gwct_apb_burst_master.sv
// rtl/gwct_apb_burst_master.sv - APB burst master: 1..2^LEN_W beats, incr/fixed addressing, streamed data
// Optional ACCESS-phase PREADY timeout is enabled by defining GWCT_TIMEOUT_EN.
module gwct_apb_burst_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned TIMEOUT = 1024,
    parameter logic [2:0]  PROT    = 3'b000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic                  cmd_write,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  cmd_incr,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  done,
    output logic                  resp_err,
    output logic                  resp_timeout,
    output logic [LEN_W:0]        resp_beats,
    output logic [ADDR_W-1:0]     PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_W-1:0]     PWDATA,
    output logic [DATA_W/8-1:0]   PSTRB,
    output logic [2:0]            PPROT,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [2:0] {
        S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_RPUSH, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

    state_t             state_q, state_d;
    logic               alive_q;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               write_q, write_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               incr_q, incr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [LEN_W:0]     beats_q, beats_d;
    logic               err_q, err_d;

    logic [LEN_W:0]     len_plus1;
    logic [LEN_W:0]     beats_nxt;
    logic [ADDR_W-1:0]  addr_adv;
    logic               timed_out;

    assign len_plus1 = {1'b0, len_q} + (LEN_W+1)'(1);
    assign beats_nxt = beats_q + (LEN_W+1)'(1);
    assign addr_adv  = incr_q ? addr_q + ADDR_STEP : addr_q;

`ifdef GWCT_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
    logic               to_q, to_d;

    assign timed_out    = (state_q == S_ACCESS) && !PREADY && (tcnt_q == TCNT_W'(TIMEOUT - 1));
    assign resp_timeout = to_q;

    always_comb begin
        tcnt_d = tcnt_q;
        to_d   = to_q;
        if (state_q == S_IDLE && cmd_valid && alive_q) begin
            to_d = 1'b0;
        end
        if (state_q == S_SETUP) begin
            tcnt_d = '0;
        end else if (state_q == S_ACCESS && !PREADY) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
        end
        if (timed_out) begin
            to_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tcnt_q <= '0;
            to_q   <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            to_q   <= to_d;
        end
    end
`else
    assign timed_out    = 1'b0;
    assign resp_timeout = (TIMEOUT == 0) && 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        len_d     = len_q;
        incr_d    = incr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        beats_d   = beats_q;
        err_d     = err_q;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        done      = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        // An error beat is always the last one delivered on the read stream.
        rd_last   = (state_q == S_RPUSH) && ((beats_q == len_plus1) || err_q);

        case (state_q)
            S_IDLE: begin
                cmd_ready = alive_q;
                if (cmd_valid && alive_q) begin
                    addr_d  = cmd_addr;
                    write_d = cmd_write;
                    len_d   = cmd_len;
                    incr_d  = cmd_incr;
                    beats_d = '0;
                    err_d   = 1'b0;
                    state_d = cmd_write ? S_WDATA : S_SETUP;
                end
            end
            S_WDATA: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    wdata_d = wr_data;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                PSEL    = 1'b1;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    beats_d = beats_nxt;
                    rdata_d = PRDATA;
                    err_d   = err_q | PSLVERR;
                    if (!write_q) begin
                        state_d = S_RPUSH;
                    end else if (PSLVERR || beats_nxt == len_plus1) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_adv;
                        state_d = S_WDATA;
                    end
                end else if (timed_out) begin
                    state_d = S_DONE;
                end
            end
            S_RPUSH: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    if (rd_last) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_adv;
                        state_d = S_SETUP;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            alive_q <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            len_q   <= '0;
            incr_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            beats_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            addr_q  <= addr_d;
            write_q <= write_d;
            len_q   <= len_d;
            incr_q  <= incr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            beats_q <= beats_d;
            err_q   <= err_d;
        end
    end

    assign rd_data    = rdata_q;
    assign resp_err   = err_q;
    assign resp_beats = beats_q;
    assign PADDR      = addr_q;
    assign PWRITE     = write_q;
    assign PWDATA     = wdata_q;
    assign PSTRB      = '1;
    assign PPROT      = PROT;

endmodule

// File: tb/tb_gwct_apb_burst_master.sv
// tb/tb_gwct_apb_burst_master.sv - directed self-checking bench for gwct_apb_burst_master
module tb_gwct_apb_burst_master;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_len = '0;
    logic        cmd_incr = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic        done;
    logic        resp_err;
    logic        resp_timeout;
    logic [8:0]  resp_beats;
    logic [31:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready = 1'b1;
    logic        pslverr;

    logic        err_en = 1'b0;
    int          err_at = 0;
    int          xfer_cnt = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
    logic [31:0] paddr_log [0:255];
    logic [31:0] rd_log    [0:255];
    logic        rdl_log   [0:255];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign prdata  = paddr ^ 32'hA5A5_A5A5;
    assign pslverr = err_en && (xfer_cnt == err_at);

    gwct_apb_burst_master #(
        .ADDR_W(32), .DATA_W(32), .LEN_W(8), .TIMEOUT(16), .PROT(3'b000)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_len(cmd_len), .cmd_incr(cmd_incr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .resp_err(resp_err), .resp_timeout(resp_timeout), .resp_beats(resp_beats),
        .PADDR(paddr), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PSTRB(pstrb), .PPROT(pprot), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    always @(posedge clk) begin
        if (psel && penable && pready) begin
            paddr_log[xfer_cnt[7:0]] <= paddr;
            xfer_cnt <= xfer_cnt + 1;
        end
        if (rd_valid && rd_ready) begin
            rd_log[rd_cnt[7:0]]  <= rd_data;
            rdl_log[rd_cnt[7:0]] <= rd_last;
            rd_cnt <= rd_cnt + 1;
        end
        if (wr_valid && wr_ready) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic issue_cmd(input logic [31:0] a, input logic w, input logic [7:0] l, input logic inc);
        int k;
        k = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_ready_wait got %0b exp 1", cmd_ready); end
        cmd_addr = a; cmd_write = w; cmd_len = l; cmd_incr = inc; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready got %0b exp 0", cmd_ready); end
        n_checks++; if (psel !== 1'b0 || penable !== 1'b0) begin n_fail++; $display("FAIL reset_psel got %0b%0b exp 00", psel, penable); end
        n_checks++; if (pstrb !== 4'hF) begin n_fail++; $display("FAIL reset_pstrb got %0h exp f", pstrb); end
        n_checks++; if (pprot !== 3'b000) begin n_fail++; $display("FAIL reset_pprot got %0h exp 0", pprot); end
        n_checks++; if (done !== 1'b0 || resp_beats !== 9'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b0 || paddr !== 32'h0)
            begin n_fail++; $display("FAIL reset_outputs got done=%0b beats=%0d rdv=%0b wrr=%0b paddr=%0h exp zeros", done, resp_beats, rd_valid, wr_ready, paddr); end
        rstn = 1'b1;
        #1;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_release_early got %0b exp 0", cmd_ready); end
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %0b exp 1", cmd_ready); end
    endtask

    task automatic test_single_write;
        int bx;
        bx = xfer_cnt;
        wr_data = 32'hDEAD_BEEF; wr_valid = 1'b1;
        issue_cmd(32'h4000_0010, 1'b1, 8'd0, 1'b1);
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL sw_wr_ready_c1 got %0b exp 1", wr_ready); end
        @(negedge clk);
        n_checks++; if (psel !== 1'b1 || penable !== 1'b0) begin n_fail++; $display("FAIL sw_setup_c2 got %0b%0b exp 10", psel, penable); end
        wr_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (psel !== 1'b1 || penable !== 1'b1) begin n_fail++; $display("FAIL sw_access_c3 got %0b%0b exp 11", psel, penable); end
        n_checks++; if (paddr !== 32'h4000_0010 || pwdata !== 32'hDEAD_BEEF || pwrite !== 1'b1)
            begin n_fail++; $display("FAIL sw_apb_fields got %0h %0h %0b exp 40000010 deadbeef 1", paddr, pwdata, pwrite); end
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || resp_beats !== 9'd1 || resp_err !== 1'b0)
            begin n_fail++; $display("FAIL sw_done_c4 got done=%0b beats=%0d err=%0b exp 1 1 0", done, resp_beats, resp_err); end
        n_checks++; if (xfer_cnt - bx !== 1) begin n_fail++; $display("FAIL sw_xfers got %0d exp 1", xfer_cnt - bx); end
    endtask

    task automatic test_incr_read;
        int bx, br;
        bit ok;
        bx = xfer_cnt; br = rd_cnt;
        issue_cmd(32'h100, 1'b0, 8'd3, 1'b1);
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ir_done_timeout got none exp done"); end
        n_checks++; if (resp_beats !== 9'd4 || resp_err !== 1'b0) begin n_fail++; $display("FAIL ir_resp got beats=%0d err=%0b exp 4 0", resp_beats, resp_err); end
        n_checks++; if (xfer_cnt - bx !== 4 || rd_cnt - br !== 4) begin n_fail++; $display("FAIL ir_counts got x=%0d r=%0d exp 4 4", xfer_cnt - bx, rd_cnt - br); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (paddr_log[bx + i] !== 32'h100 + 32'(4 * i))
                begin n_fail++; $display("FAIL ir_paddr[%0d] got %0h exp %0h", i, paddr_log[bx + i], 32'h100 + 32'(4 * i)); end
            n_checks++; if (rd_log[br + i] !== ((32'h100 + 32'(4 * i)) ^ 32'hA5A5_A5A5))
                begin n_fail++; $display("FAIL ir_rd_data[%0d] got %0h exp %0h", i, rd_log[br + i], (32'h100 + 32'(4 * i)) ^ 32'hA5A5_A5A5); end
            n_checks++; if (rdl_log[br + i] !== (i == 3))
                begin n_fail++; $display("FAIL ir_rd_last[%0d] got %0b exp %0b", i, rdl_log[br + i], (i == 3)); end
        end
    endtask

    task automatic test_fixed_read_stall;
        int bx, br, k;
        bit ok;
        logic [31:0] held;
        bx = xfer_cnt; br = rd_cnt;
        rd_ready = 1'b0;
        issue_cmd(32'h200, 1'b0, 8'd2, 1'b0);
        k = 0;
        while (rd_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL fr_rd_valid_wait got %0b exp 1", rd_valid); end
        held = rd_data;
        n_checks++; if (held !== 32'hA5A5_A7A5) begin n_fail++; $display("FAIL fr_first_data got %0h exp a5a5a7a5", held); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (rd_valid !== 1'b1 || rd_data !== held || rd_last !== 1'b0 || psel !== 1'b0)
                begin n_fail++; $display("FAIL fr_stall[%0d] got v=%0b d=%0h l=%0b psel=%0b exp 1 %0h 0 0", i, rd_valid, rd_data, rd_last, psel, held); end
        end
        rd_ready = 1'b1;
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL fr_done_timeout got none exp done"); end
        n_checks++; if (resp_beats !== 9'd3 || xfer_cnt - bx !== 3) begin n_fail++; $display("FAIL fr_beats got %0d/%0d exp 3", resp_beats, xfer_cnt - bx); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (paddr_log[bx + i] !== 32'h200 || rd_log[br + i] !== 32'hA5A5_A7A5 || rdl_log[br + i] !== (i == 2))
                begin n_fail++; $display("FAIL fr_beat[%0d] got a=%0h d=%0h l=%0b exp 200 a5a5a7a5 %0b", i, paddr_log[bx + i], rd_log[br + i], rdl_log[br + i], (i == 2)); end
        end
    endtask

    task automatic test_write_error;
        int bx, bw;
        bit ok;
        bx = xfer_cnt; bw = wr_cnt;
        err_en = 1'b1; err_at = bx + 1;
        wr_data = 32'h1234_5678; wr_valid = 1'b1;
        issue_cmd(32'h500, 1'b1, 8'd3, 1'b1);
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL we_done_timeout got none exp done"); end
        n_checks++; if (resp_err !== 1'b1 || resp_beats !== 9'd2) begin n_fail++; $display("FAIL we_resp got err=%0b beats=%0d exp 1 2", resp_err, resp_beats); end
        repeat (5) @(negedge clk);
        n_checks++; if (xfer_cnt - bx !== 2 || wr_cnt - bw !== 2) begin n_fail++; $display("FAIL we_counts got x=%0d w=%0d exp 2 2", xfer_cnt - bx, wr_cnt - bw); end
        n_checks++; if (paddr_log[bx + 1] !== 32'h504) begin n_fail++; $display("FAIL we_paddr1 got %0h exp 504", paddr_log[bx + 1]); end
        err_en = 1'b0; wr_valid = 1'b0;
    endtask

    task automatic test_wrap_and_reset;
        int bx, bd, k;
        bx = xfer_cnt;
        wr_data = 32'h0BAD_F00D; wr_valid = 1'b1;
        issue_cmd(32'hFFFF_FFFC, 1'b1, 8'd1, 1'b1);
        k = 0;
        while (xfer_cnt == bx && k < 50) begin @(negedge clk); k++; end
        pready = 1'b0;
        n_checks++; if (xfer_cnt - bx !== 1 || paddr_log[bx] !== 32'hFFFF_FFFC)
            begin n_fail++; $display("FAIL wr_first got n=%0d a=%0h exp 1 fffffffc", xfer_cnt - bx, paddr_log[bx]); end
        k = 0;
        while (penable !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        n_checks++; if (penable !== 1'b1 || paddr !== 32'h0) begin n_fail++; $display("FAIL wr_second_paddr got en=%0b a=%0h exp 1 0", penable, paddr); end
        bd = done_cnt;
        rstn = 1'b0;
        #1;
        n_checks++; if (psel !== 1'b0 || penable !== 1'b0) begin n_fail++; $display("FAIL wr_async_drop got %0b%0b exp 00", psel, penable); end
        repeat (3) @(negedge clk);
        rstn = 1'b1; pready = 1'b1; wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (done_cnt !== bd || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_no_done got dones=%0d rdy=%0b exp 0 1", done_cnt - bd, cmd_ready); end
    endtask

`ifdef GWCT_TIMEOUT_EN
    task automatic test_timeout;
        int br, cnt;
        br = rd_cnt; cnt = 0;
        pready = 1'b0;
        issue_cmd(32'h300, 1'b0, 8'd0, 1'b1);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (penable === 1'b1) cnt++;
            else if (cnt > 0) break;
        end
        n_checks++; if (cnt !== 16) begin n_fail++; $display("FAIL to_access_cycles got %0d exp 16", cnt); end
        n_checks++; if (psel !== 1'b0 || done !== 1'b1 || resp_timeout !== 1'b1 || resp_beats !== 9'd0)
            begin n_fail++; $display("FAIL to_resp got psel=%0b done=%0b to=%0b beats=%0d exp 0 1 1 0", psel, done, resp_timeout, resp_beats); end
        pready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (rd_cnt !== br) begin n_fail++; $display("FAIL to_no_push got %0d exp 0", rd_cnt - br); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_incr_read();
        test_fixed_read_stall();
        test_write_error();
        test_wrap_and_reset();
`ifdef GWCT_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
